// File: rtl/stream_mux_pkg.sv
// Shared encodings and helpers for the stream mux family and its arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {
        OREG_EMPTY = 1'b0,
        OREG_FULL  = 1'b1
    } oreg_state_t;

    // Index width that never collapses to zero bits, so single-bit selects stay legal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (wrapping), or a held lock index.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant with its own ready.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    input  logic            lock_vld_i,
    input  logic [SELW-1:0] lock_idx_i,
    output logic [SELW-1:0] gnt_idx_o,
    output logic            gnt_vld_o
);

    logic [SELW-1:0] idx;

    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        if (lock_vld_i) begin
            gnt_idx_o = lock_idx_i;
            gnt_vld_o = 1'b1;
        end else begin
            // Scan farthest-first so the nearest requester after ptr wins last.
            for (int i = N - 1; i >= 0; i--) begin
                idx = SELW'((int'(ptr_i) + i) % N);
                if (req_i[idx]) begin
                    gnt_idx_o = idx;
                    gnt_vld_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux, external select or round-robin; STREAM_MUX_PKT_LOCK_EN adds packet lock.
// Latency: 1 cycle from input transfer to out_valid (registered output stage).
// Backpressure: in_ready of the granted channel follows out_ready when full; 1 beat/cycle.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [N-1:0]    in_last,
    output logic            out_last,
`endif
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_chan,
    output logic            out_valid,
    input  logic            out_ready
);

    oreg_state_t     state_q, state_d;
    logic [W-1:0]    data_q, data_d;
    logic [SELW-1:0] chan_q, chan_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

    logic            lock_vld;
    logic [SELW-1:0] lock_idx;
    logic [SELW-1:0] arb_idx, gnt_idx;
    logic            arb_vld, gnt_vld, sel_hit;
    logic            gnt_in_vld, gnt_last, can_load, xfer;
    logic [W-1:0]    gnt_data;

`ifdef STREAM_MUX_PKT_LOCK_EN
    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [0:0]      lock_st_q, lock_st_d;
    logic [SELW-1:0] lock_idx_q, lock_idx_d;
    logic            last_q, last_d;

    assign lock_vld = (lock_st_q == ST_LOCKED);
    assign lock_idx = lock_idx_q;
    assign out_last = last_q;
`else
    assign lock_vld = 1'b0;
    assign lock_idx = '0;
`endif

    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .req_i      (in_valid),
        .ptr_i      (rr_ptr_q),
        .lock_vld_i (lock_vld),
        .lock_idx_i (lock_idx),
        .gnt_idx_o  (arb_idx),
        .gnt_vld_o  (arb_vld)
    );

    // Out-of-range selects simply never match, so they produce no grant.
    always_comb begin
        sel_hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k) && in_valid[k]) sel_hit = 1'b1;
        end
    end

    always_comb begin
        if (lock_vld || mode == MODE_RR) begin
            gnt_vld = arb_vld;
            gnt_idx = arb_idx;
        end else begin
            gnt_vld = sel_hit;
            gnt_idx = sel;
        end
    end

    assign can_load = (state_q == OREG_EMPTY) || out_ready;

    always_comb begin
        gnt_data   = '0;
        gnt_in_vld = 1'b0;
        gnt_last   = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = rst_n && gnt_vld && can_load && (gnt_idx == SELW'(k));
            if (gnt_idx == SELW'(k)) begin
                gnt_data   = in_data[k*W +: W];
                gnt_in_vld = in_valid[k];
`ifdef STREAM_MUX_PKT_LOCK_EN
                gnt_last   = in_last[k];
`endif
            end
        end
    end

    assign xfer = gnt_vld && gnt_in_vld && can_load;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        chan_d   = chan_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            state_d = OREG_FULL;
            data_d  = gnt_data;
            chan_d  = gnt_idx;
            if (mode == MODE_RR && gnt_last)
                rr_ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
        end else if (out_ready) begin
            state_d = OREG_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OREG_EMPTY;
            data_q   <= '0;
            chan_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_comb begin
        lock_st_d  = lock_st_q;
        lock_idx_d = lock_idx_q;
        last_d     = last_q;
        if (xfer) begin
            lock_st_d  = gnt_last ? ST_UNLOCKED : ST_LOCKED;
            lock_idx_d = gnt_idx;
            last_d     = gnt_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_st_q  <= ST_UNLOCKED;
            lock_idx_q <= '0;
            last_q     <= 1'b0;
        end else begin
            lock_st_q  <= lock_st_d;
            lock_idx_q <= lock_idx_d;
            last_q     <= last_d;
        end
    end
`endif

    assign out_valid = (state_q == OREG_FULL);
    assign out_data  = data_q;
    assign out_chan  = chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized bench for stream_mux_rr against a beat-level reference model, plus an N=3 instance.
module tb_stream_mux_rr;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid, in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_chan;
    logic            out_valid, out_ready;

    logic [3*W-1:0]  in_data3;
    logic [2:0]      in_valid3, in_ready3;
    logic            mode3;
    logic [1:0]      sel3;
    logic [W-1:0]    out_data3;
    logic [1:0]      out_chan3;
    logic            out_valid3, out_ready3;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [N-1:0]    in_last;
    logic            out_last;
    logic [2:0]      in_last3;
    logic            out_last3;
`endif

    stream_mux_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_mux_rr #(.N(3), .W(W)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last   (in_last3),
        .out_last  (out_last3),
`endif
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents of the output slot and the round-robin start point.
    bit           m_vld;
    logic [W-1:0] m_data;
    int           m_chan;
    int           m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        bit           gv;
        int           g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        gv = 1'b0;
        g  = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) begin
                gv = 1'b1;
                g  = int'(sel);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                int k = (m_ptr + i) % N;
                if (!gv && in_valid[k]) begin
                    gv = 1'b1;
                    g  = k;
                end
            end
        end
        exp_rdy = (gv && (!m_vld || out_ready)) ? N'(1 << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        if (m_vld) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_chan", 32'(out_chan), 32'(m_chan));
        end
        @(posedge clk);
        if (exp_rdy != '0) begin
            m_vld  = 1'b1;
            m_data = in_data[g*W +: W];
            m_chan = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_vld = 1'b0;
        end
        #1;
    endtask

    task automatic rand_inputs();
        in_valid  = N'($urandom);
        in_data   = $urandom;
        mode      = 1'($urandom_range(0, 1));
        sel       = SELW'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '1;
        in_data   = 32'h13121110;
        mode      = 1'b0;
        sel       = 2'd2;
        out_ready = 1'b1;
        in_data3   = 24'h222120;
        in_valid3  = 3'b111;
        mode3      = 1'b0;
        sel3       = 2'd3;
        out_ready3 = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        in_last  = '1;
        in_last3 = '1;
`endif
        m_vld  = 1'b0;
        m_data = '0;
        m_chan = 0;
        m_ptr  = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_data", 32'(out_data), 32'h0);
        chk("rst out_chan", 32'(out_chan), 32'h0);
        chk("rst in_ready3", 32'(in_ready3), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // External select of channel 2, all valid.
        repeat (6) cycle();

        // Invalid selects: channel 3 not valid here; index 3 beyond an N=3 mux.
        sel      = 2'd3;
        in_valid = 4'b0111;
        repeat (3) cycle();
        chk("n3 oob in_ready", 32'(in_ready3), 32'h0);
        chk("n3 oob out_valid", 32'(out_valid3), 32'h0);
        sel3 = 2'd2;
        #1;
        chk("n3 sel2 in_ready", 32'(in_ready3), 32'h4);
        cycle();
        chk("n3 sel2 out_valid", 32'(out_valid3), 32'h1);
        chk("n3 sel2 out_chan", 32'(out_chan3), 32'h2);
        chk("n3 sel2 out_data", 32'(out_data3), 32'h22);

        // Round-robin, all valid then sparse.
        mode     = 1'b1;
        in_valid = 4'b1111;
        repeat (8) cycle();
        in_valid = 4'b1010;
        repeat (6) cycle();

        // Backpressure: one beat in, stall five cycles, then drain.
        in_valid = 4'b1111;
        cycle();
        out_ready = 1'b0;
        repeat (5) cycle();
        out_ready = 1'b1;
        repeat (4) cycle();

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            cycle();
        end

        // Asynchronous reset mid-stream discards the held beat immediately.
        mode      = 1'b1;
        in_valid  = '1;
        out_ready = 1'b0;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'h0);
        chk("midrst out_data", 32'(out_data), 32'h0);
        chk("midrst out_chan", 32'(out_chan), 32'h0);
        chk("midrst in_ready", 32'(in_ready), 32'h0);
        m_vld  = 1'b0;
        m_ptr  = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) cycle();

        for (int n = 0; n < 100; n++) begin
            rand_inputs();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
